bcd_sevenseg_scan: RTL

Display-side consumer of the BCD up/down counter. Takes a 4-digit packed BCD value and drives the Basys3 4-digit multiplexed seven-segment display (active-low segments and anodes). A refresh divider scans one digit at a time, and the value is latched once per scan frame so the display never tears. Optional leading-zero blanking and per-digit decimal points are supported. Sits between the counter's count output (zero-extended to 16 bits) and the board seg/an/dp pins.

---
 rtl/sevenseg_pkg.sv | 32 +++
 rtl/bcd7seg_decode.sv | 18 +
 rtl/bcd_sevenseg_scan.sv | 91 +++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: segment type, digit/dash/blank patterns,
// scan-slot encoding and the active-low anode helper.
package sevenseg_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned NIBBLE_W = 4;

    typedef logic [SEG_W-1:0] seg_t;

    // Scan slot, one per display digit
    typedef enum logic [1:0] {
        SCAN_D0 = 2'd0,
        SCAN_D1 = 2'd1,
        SCAN_D2 = 2'd2,
        SCAN_D3 = 2'd3
    } scan_t;

    // Active-low patterns, bit 0 = segment a .. bit 6 = segment g
    localparam seg_t SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low one-hot anode pattern for a digit slot
    function automatic logic [DIGITS-1:0] an_onehot(input logic [1:0] idx);
        return ~(DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/bcd7seg_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Ports: nibble (4-bit BCD digit in), seg (active-low segments out, _c-style
// combinational; non-BCD codes A-F show a dash).
module bcd7seg_decode
    import sevenseg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output seg_t                seg
);

    always_comb begin
        seg = SEG_DASH;
        if (nibble < NIBBLE_W'(10)) begin
            seg = SEG_DIGIT[nibble];
        end
    end

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Multiplexed 4-digit seven-segment driver for a packed BCD value.
// A refresh divider steps the scan one digit per REFRESH_DIV cycles; the
// input value and display controls are latched once per frame so a frame
// never mixes two values.
// Ports: clk, reset (sync, active-high), value (packed BCD, digit0 in [3:0]),
// blank_lz (blank leading zeros), dp_en (per-digit decimal point),
// seg/dp/an (registered, active-low display pins).
module bcd_sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter  int unsigned REFRESH_DIV = 100000,
    localparam int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DIGITS*NIBBLE_W-1:0]   value,
    input  logic                         blank_lz,
    input  logic [DIGITS-1:0]            dp_en,
    output seg_t                         seg,
    output logic                         dp,
    output logic [DIGITS-1:0]            an
);

    logic [CNT_W-1:0]               div_cnt;
    logic                           tick;
    scan_t                          idx;
    logic [DIGITS*NIBBLE_W-1:0]     shadow_value;
    logic                           shadow_blank_lz;
    logic [DIGITS-1:0]              shadow_dp_en;
    logic [NIBBLE_W-1:0]            digit;
    logic                           blank;
    seg_t                           dec_seg;

    assign tick = (div_cnt == CNT_W'(REFRESH_DIV - 1));

    // Current digit nibble and leading-zero blanking for the active slot
    always_comb begin
        digit = shadow_value[3:0];
        blank = 1'b0;
        case (idx)
            SCAN_D0: digit = shadow_value[3:0];
            SCAN_D1: begin
                digit = shadow_value[7:4];
                blank = shadow_blank_lz && (shadow_value[15:4] == 12'h000);
            end
            SCAN_D2: begin
                digit = shadow_value[11:8];
                blank = shadow_blank_lz && (shadow_value[15:8] == 8'h00);
            end
            SCAN_D3: begin
                digit = shadow_value[15:12];
                blank = shadow_blank_lz && (shadow_value[15:12] == 4'h0);
            end
            default: ;
        endcase
    end

    bcd7seg_decode u_decode (
        .nibble (digit),
        .seg    (dec_seg)
    );

    // Divider, scan state, frame latch and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt         <= '0;
            idx             <= SCAN_D0;
            shadow_value    <= '0;
            shadow_blank_lz <= 1'b0;
            shadow_dp_en    <= '0;
            an              <= '1;
            seg             <= SEG_BLANK;
            dp              <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
            if (tick) begin
                idx <= scan_t'(2'(idx + 2'd1));
                // Frame boundary: the next slot shown is digit0 of the new value
                if (idx == SCAN_D3) begin
                    shadow_value    <= value;
                    shadow_blank_lz <= blank_lz;
                    shadow_dp_en    <= dp_en;
                end
            end
            an  <= an_onehot(idx);
            seg <= blank ? SEG_BLANK : dec_seg;
            dp  <= blank ? 1'b1 : ~shadow_dp_en[idx];
        end
    end

endmodule
